// File: rtl/frame_dispatcher_pkg.sv
// Shared types and widths for the frame dispatcher: FSM state encoding,
// event-ID width and BUSY timeout counter width.
package frame_dispatcher_pkg;

  localparam int EID_W = 8;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DISPATCH,
    ST_BUSY,
    ST_DRAIN,
    ST_RESP
  } state_t;

endpackage

// File: rtl/frame_dispatcher_eid_match_encoder.sv
// Priority match of an event ID against the per-handler configuration:
// the lowest enabled slot whose configured ID equals eid wins.
module eid_match_encoder
  import frame_dispatcher_pkg::*;
#(
  parameter int NUM_HANDLERS = 4,
  parameter int IDX_W        = 2
) (
  input  logic [EID_W-1:0]              eid,
  input  logic [EID_W*NUM_HANDLERS-1:0] handler_eid_cfg,
  input  logic [NUM_HANDLERS-1:0]       handler_en,
  output logic [IDX_W-1:0]              sel,
  output logic                          hit
);

  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
    sel = '0;
    hit = 1'b0;
    // Scanning downwards lets the lowest matching index overwrite the others.
    for (int i = NUM_HANDLERS - 1; i >= 0; i--) begin
      if (handler_en[i] && (handler_eid_cfg[i*EID_W +: EID_W] == eid)) begin
        sel = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_dispatcher.sv
// Dispatches parsed headers to one of NUM_HANDLERS protocol handlers, supervises
// the handler with a timeout, drains rejected frames and issues ack/nak responses.
module frame_dispatcher
  import frame_dispatcher_pkg::*;
#(
  parameter int NUM_HANDLERS   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          header_done,
  input  logic [EID_W-1:0]              header_eid,
  input  logic                          packet_is_empty,
  input  logic                          is_fragment,
  input  logic                          in_frame_valid,
  input  logic [EID_W*NUM_HANDLERS-1:0] handler_eid_cfg,
  input  logic [NUM_HANDLERS-1:0]       handler_en,
  input  logic [NUM_HANDLERS-1:0]       handler_done,
  output logic                          header_done_clear,
  output logic [NUM_HANDLERS-1:0]       handler_start,
  output logic [NUM_HANDLERS-1:0]       handler_abort,
  output logic                          frame_drain,
  output logic                          ack_req,
  output logic                          nak_req,
  output logic [EID_W-1:0]              resp_eid,
  output logic                          timeout_err
);

  localparam int IDX_W = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;
  localparam logic [CNT_W-1:0]        TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_HANDLERS-1:0] ONE_HOT_0    = NUM_HANDLERS'(1);

  state_t            state;
  logic [EID_W-1:0]  eid_q;
  logic              empty_q;
  logic              frag_q;
  logic              clr_done;
  logic [IDX_W-1:0]  sel_q;
  logic              lock_valid;
  logic [EID_W-1:0]  lock_eid;
  logic [IDX_W-1:0]  lock_idx;
  logic [CNT_W-1:0]  busy_cnt;
  logic [IDX_W-1:0]  match_sel;
  logic              match_hit;

  eid_match_encoder #(
    .NUM_HANDLERS (NUM_HANDLERS),
    .IDX_W        (IDX_W)
  ) u_match (
    .eid             (eid_q),
    .handler_eid_cfg (handler_eid_cfg),
    .handler_en      (handler_en),
    .sel             (match_sel),
    .hit             (match_hit)
  );

  // Every output is set on the edge that enters the state it belongs to,
  // so pulses are visible during DISPATCH / first DRAIN / RESP cycles.
  always_ff @(posedge clk) begin
    // NOTE: state and outputs use non-blocking assignments so all registers update together.
    if (rst) begin
      state             <= ST_IDLE;
      eid_q             <= '0;
      empty_q           <= 1'b0;
      frag_q            <= 1'b0;
      clr_done          <= 1'b0;
      sel_q             <= '0;
      lock_valid        <= 1'b0;
      lock_eid          <= '0;
      lock_idx          <= '0;
      busy_cnt          <= '0;
      header_done_clear <= 1'b0;
      handler_start     <= '0;
      handler_abort     <= '0;
      frame_drain       <= 1'b0;
      ack_req           <= 1'b0;
      nak_req           <= 1'b0;
      resp_eid          <= '0;
      timeout_err       <= 1'b0;
    end else begin
      header_done_clear <= 1'b0;
      handler_start     <= '0;
      handler_abort     <= '0;
      frame_drain       <= 1'b0;
      ack_req           <= 1'b0;
      nak_req           <= 1'b0;
      timeout_err       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (header_done) begin
            eid_q    <= header_eid;
            empty_q  <= packet_is_empty;
            frag_q   <= is_fragment;
            clr_done <= 1'b0;
            state    <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (!match_hit || (lock_valid && (eid_q != lock_eid))) begin
            state <= ST_DRAIN;
          end else if (empty_q) begin
            ack_req           <= 1'b1;
            resp_eid          <= eid_q;
            header_done_clear <= 1'b1;
            clr_done          <= 1'b1;
            state             <= ST_RESP;
          end else begin
            // A locked fragment stream stays on the handler that took its first part.
            sel_q             <= lock_valid ? lock_idx : match_sel;
            handler_start     <= ONE_HOT_0 << (lock_valid ? lock_idx : match_sel);
            header_done_clear <= 1'b1;
            clr_done          <= 1'b1;
            state             <= ST_DISPATCH;
          end
        end

        ST_DISPATCH: begin
          busy_cnt <= '0;
          state    <= ST_BUSY;
        end

        ST_BUSY: begin
          if (handler_done[sel_q]) begin
            lock_valid <= frag_q;
            if (frag_q) begin
              lock_eid <= eid_q;
              lock_idx <= sel_q;
            end
            state <= ST_IDLE;
          end else if (busy_cnt == TIMEOUT_LAST) begin
            timeout_err   <= 1'b1;
            handler_abort <= ONE_HOT_0 << sel_q;
            lock_valid    <= 1'b0;
            state         <= ST_DRAIN;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (in_frame_valid) begin
            frame_drain <= 1'b1;
          end else begin
            nak_req           <= 1'b1;
            resp_eid          <= eid_q;
            header_done_clear <= !clr_done;
            clr_done          <= 1'b1;
            state             <= ST_RESP;
          end
        end

        ST_RESP: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_dispatcher.sv
// Self-checking bench: per-transaction expected output timeline derived from
// dispatch rules (match, lock, empty, timeout, drain) and compared every cycle.
module tb_frame_dispatcher;

  localparam int NH = 4;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            header_done = 1'b0;
  logic [7:0]      header_eid = '0;
  logic            packet_is_empty = 1'b0;
  logic            is_fragment = 1'b0;
  logic            in_frame_valid = 1'b0;
  logic [8*NH-1:0] handler_eid_cfg = '0;
  logic [NH-1:0]   handler_en = '0;
  logic [NH-1:0]   handler_done = '0;
  logic            header_done_clear;
  logic [NH-1:0]   handler_start;
  logic [NH-1:0]   handler_abort;
  logic            frame_drain;
  logic            ack_req;
  logic            nak_req;
  logic [7:0]      resp_eid;
  logic            timeout_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         lock_v = 1'b0;
  logic [7:0] lock_e = '0;
  int         lock_i = 0;
  logic [7:0] last_resp = '0;

  frame_dispatcher #(
    .NUM_HANDLERS   (NH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .header_done       (header_done),
    .header_eid        (header_eid),
    .packet_is_empty   (packet_is_empty),
    .is_fragment       (is_fragment),
    .in_frame_valid    (in_frame_valid),
    .handler_eid_cfg   (handler_eid_cfg),
    .handler_en        (handler_en),
    .handler_done      (handler_done),
    .header_done_clear (header_done_clear),
    .handler_start     (handler_start),
    .handler_abort     (handler_abort),
    .frame_drain       (frame_drain),
    .ack_req           (ack_req),
    .nak_req           (nak_req),
    .resp_eid          (resp_eid),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where, input bit clr, input logic [NH-1:0] start,
                               input logic [NH-1:0] abort, input bit drain, input bit ack,
                               input bit nak, input logic [7:0] reid, input bit terr);
    check({where, ".clear"},   32'(header_done_clear), 32'(clr));
    check({where, ".start"},   32'(handler_start),     32'(start));
    check({where, ".abort"},   32'(handler_abort),     32'(abort));
    check({where, ".drain"},   32'(frame_drain),       32'(drain));
    check({where, ".ack"},     32'(ack_req),           32'(ack));
    check({where, ".nak"},     32'(nak_req),           32'(nak));
    check({where, ".resp_eid"},32'(resp_eid),          32'(reid));
    check({where, ".timeout"}, 32'(timeout_err),       32'(terr));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst            = 1'b0;
      header_done    = 1'b0;
      in_frame_valid = 1'($urandom);
      handler_done   = NH'($urandom);
      @(negedge clk);
      check_outputs($sformatf("idle%0d", k), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, last_resp, 1'b0);
    end
  endtask

  // One header from its header_done cycle (k=0) until the DUT is back in IDLE.
  // dd: BUSY cycle index at which handler_done[sel] is raised (-1 = never).
  // len: number of cycles in_frame_valid stays high once draining starts.
  // rst_at: cycle in which rst is raised (-1 = none).
  task automatic run_txn(input logic [7:0] eid, input bit empty, input bit frag,
                         input int dd, input int len, input int rst_at);
    int sel_m = 0;
    bit hit = 1'b0;
    bit disp = 1'b0;
    bit tmo = 1'b0;
    int start_c = -1, clr_c = -1, abort_c = -1, ack_c = -1, nak_c = -1;
    int ds = 1000;
    int e_cyc;
    logic [NH-1:0] sel_oh;
    for (int i = 0; i < NH; i++)
      if (!hit && handler_en[i] && handler_eid_cfg[i*8 +: 8] == eid) begin
        hit = 1'b1;
        sel_m = i;
      end
    if ((lock_v && eid != lock_e) || !hit) begin
      ds = 2; nak_c = ds + len + 1; clr_c = nak_c; e_cyc = ds + len + 2;
    end else if (empty) begin
      ack_c = 2; clr_c = 2; e_cyc = 3;
    end else begin
      disp = 1'b1;
      if (lock_v) sel_m = lock_i;
      start_c = 2; clr_c = 2;
      if (dd < 0 || dd >= TO) begin
        tmo = 1'b1; ds = 3 + TO; abort_c = ds; nak_c = ds + len + 1; e_cyc = ds + len + 2;
      end else begin
        e_cyc = 4 + dd;
      end
    end
    if (rst_at >= 0) e_cyc = rst_at + 1;
    sel_oh = NH'(1) << sel_m;

    for (int k = 0; k < e_cyc; k++) begin
      logic [NH-1:0] hd;
      @(posedge clk); #1;
      rst             = (k == rst_at);
      header_done     = (k == 0) ? 1'b1 : 1'($urandom);
      header_eid      = (k == 0) ? eid : 8'($urandom);
      packet_is_empty = (k == 0) ? empty : 1'($urandom);
      is_fragment     = (k == 0) ? frag : 1'($urandom);
      in_frame_valid  = (k >= ds) ? (k < ds + len) : 1'($urandom);
      hd = NH'($urandom);
      if (disp) hd = hd & ~sel_oh;
      if (disp && dd >= 0 && k == 3 + dd) hd = hd | sel_oh;
      handler_done = hd;
      @(negedge clk);
      if (k == ack_c || k == nak_c) last_resp = eid;
      check_outputs($sformatf("eid%0h@%0d", eid, k), k == clr_c,
                    (k == start_c) ? sel_oh : '0, (k == abort_c) ? sel_oh : '0,
                    (k > ds && k <= ds + len), k == ack_c, k == nak_c, last_resp, k == abort_c);
    end

    if (rst_at >= 0) begin
      lock_v = 1'b0;
      last_resp = '0;
    end else if (tmo) begin
      lock_v = 1'b0;
    end else if (disp) begin
      lock_v = frag;
      if (frag) begin
        lock_e = eid;
        lock_i = sel_m;
      end
    end
  endtask

  initial begin
    logic [7:0] pool [4];
    pool[0] = 8'h42; pool[1] = 8'h43; pool[2] = 8'h17; pool[3] = 8'h99;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    handler_eid_cfg = {8'h43, 8'h42, 8'h17, 8'h42};
    handler_en      = 4'b1111;
    idle_cycles(2);

    // Lowest matching slot wins, start 2 cycles after header_done
    run_txn(8'h42, 1'b0, 1'b0, 3, 0, -1);
    // No match: drain 5 cycles, nak with one clear
    run_txn(8'h99, 1'b0, 1'b0, -1, 5, -1);
    // Handler never done: timeout after TO BUSY cycles, then nak
    run_txn(8'h42, 1'b0, 1'b0, -1, 2, -1);
    // Fragment lock: mismatch naks and keeps the lock, final non-fragment clears it
    run_txn(8'h42, 1'b0, 1'b1, 2, 0, -1);
    run_txn(8'h43, 1'b0, 1'b0, 2, 1, -1);
    run_txn(8'h42, 1'b0, 1'b0, 1, 0, -1);
    run_txn(8'h43, 1'b0, 1'b0, 0, 0, -1);
    // Empty packet: ack, no start
    run_txn(8'h42, 1'b1, 1'b0, 0, 0, -1);
    // handler_done on the timeout cycle wins
    run_txn(8'h42, 1'b0, 1'b0, TO - 1, 0, -1);
    // Disabled slot never matches
    handler_en = 4'b1110;
    run_txn(8'h42, 1'b0, 1'b0, 0, 0, -1);
    handler_en = 4'b1111;
    // Reset during BUSY and during DRAIN: silent abort
    run_txn(8'h42, 1'b0, 1'b0, -1, 0, 6);
    idle_cycles(4);
    run_txn(8'h99, 1'b0, 1'b0, -1, 5, 4);
    idle_cycles(4);

    // Randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NH; i++) handler_eid_cfg[i*8 +: 8] = pool[$urandom_range(0, 3)];
        handler_en = NH'($urandom);
      end
      run_txn(pool[$urandom_range(0, 3)], $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 4) == 0 ? -1 : int'($urandom_range(0, TO + 2)),
              int'($urandom_range(0, 4)), -1);
      if ($urandom_range(0, 2) == 0) idle_cycles(1);
    end
    idle_cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
